alu_multdiv: RTL and testbench

- Iterative multiply/divide unit directly downstream of the ALU operand-B select mux in the MIPS datapath.
- Consumes operand A (Read_data01) and the selected operand B (Read_data02) and produces the 64-bit HI/LO result for MULT, MULTU, DIV and DIVU.
- Fixed-latency operation with a start/busy/done handshake; control stalls the pipeline while busy is high.

---
 rtl/alu_multdiv.sv | 166 ++++++++++++++++
 tb/tb_alu_multdiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multdiv.sv
// rtl/alu_multdiv.sv - iterative signed/unsigned multiply/divide unit producing HI/LO
module alu_multdiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Read_data01,
  input  logic [WIDTH-1:0] Read_data02,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;          // product or quotient negated in FIX
  logic                 neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;      // original A, returned as HI on divide-by-zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;          // {hi, lo} product or {rem, quot}

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // Operand magnitudes, one shift-add / trial-subtract step, and final sign fix-up
  always_comb begin
    a_neg      = ~op[0] & Read_data01[WIDTH-1];
    b_neg      = ~op[0] & Read_data02[WIDTH-1];
    a_mag      = a_neg ? -Read_data01 : Read_data01;
    b_mag      = b_neg ? -Read_data02 : Read_data02;
    mul_addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    // remainder shifted left needs WIDTH+1 bits before the subtract
    div_trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    prod_fix   = neg_q ? -acc_q : acc_q;
    quot_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control for IDLE -> CALC x WIDTH -> FIX
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_div_d      = is_div_q;
    neg_d         = neg_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    opnd_d        = opnd_q;
    a_raw_d       = a_raw_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    acc_d         = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = op[1] && (Read_data02 == {WIDTH{1'b0}});
          a_raw_d   = Read_data01;
          opnd_d    = op[1] ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        div_by_zero_d = dbz_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation and clears results
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      opnd_q        <= '0;
      a_raw_q       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_div_q      <= is_div_d;
      neg_q         <= neg_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      opnd_q        <= opnd_d;
      a_raw_q       <= a_raw_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      acc_q         <= acc_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// tb/tb_alu_multdiv.sv - vector, corner-sequence and randomized check of alu_multdiv
module tb_alu_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Read_data01;
  logic [31:0] Read_data02;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  always #5 clock = ~clock;

  alu_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .Read_data01 (Read_data01),
    .Read_data02 (Read_data02),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = 64'h0;
    dbz = 1'b0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin
          dbz = 1'b1;
          p   = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) begin
          dbz = 1'b1;
          p   = {a, 32'hFFFF_FFFF};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op          = o;
    Read_data01 = a;
    Read_data02 = b;
    start       = 1'b1;
  endtask

  // Waits from the start edge to the done cycle, scrambling inputs after E0
  task automatic wait_done(input bit pokes, output int edges, output int busy_cycles);
    edges       = -1;
    busy_cycles = 0;
    @(posedge clock);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start       = pokes && (k == 5 || k == 20);
      op          = 2'($urandom);
      Read_data01 = $urandom;
      Read_data02 = $urandom;
      if (done) begin
        edges = k - 1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                               input logic edbz, input bit pokes);
    int edges;
    int bc;
    issue(o, a, b);
    wait_done(pokes, edges, bc);
    check({name, " latency"}, edges, 33);
    check({name, " busy_cycles"}, bc, 33);
    check({name, " busy_at_done"}, busy, 0);
    check({name, " HI"}, HI, ehi);
    check({name, " LO"}, LO, elo);
    check({name, " div_by_zero"}, div_by_zero, edbz);
  endtask

  task automatic hold_check(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clock);
    check({name, " done_one_cycle"}, done, 0);
    check({name, " HI_hold"}, HI, ehi);
    check({name, " LO_hold"}, LO, elo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, ehi, elo;
    logic        edbz;
    bit          seen_done;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,        32'd14,        1'b0};
    vecs[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    reset       = 1'b1;
    start       = 1'b0;
    op          = 2'b00;
    Read_data01 = 32'h0;
    Read_data02 = 32'h0;
    repeat (3) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset HI", HI, 0);
    check("reset LO", LO, 0);
    check("reset div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].dbz, 1'b0);
      hold_check($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end

    // Mid-operation start pulses with scrambled operands, then a start in the done cycle
    run_and_check("pokes", 2'b01, 32'd1234, 32'd5678, 32'h0, 32'd7006652, 1'b0, 1'b1);
    run_and_check("b2b", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    hold_check("b2b", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Reset at cycle 10 of a MULT
    issue(2'b00, 32'h7FFF_FFFF, 32'h0001_2345);
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset HI", HI, 0);
    check("midreset LO", LO, 0);
    reset     = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    check("midreset no_done", seen_done, 0);
    run_and_check("after_reset", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);
    hold_check("after_reset", 32'd0, 32'd15);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(ro, ra, rb, ehi, elo, edbz);
      run_and_check($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, ehi, elo, edbz, 1'b0);
      if (i % 2 == 0) hold_check($sformatf("rand%0d", i), ehi, elo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
